// File: rtl/viterbi_decoder.sv
// Hard-decision K=7 (133/171) Viterbi decoder: 64-state ACS with register-exchange
// survivors, erasure-aware branch metrics, one decoded bit per beat on AXI-stream.
module viterbi_decoder #(
  parameter int DEPTH = 42,
  parameter int PMW   = 8
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] s_axis_tdata,
  input  logic [1:0] s_axis_tuser,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic       m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast
);

  localparam int NS = 64;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  TAIL_C  = CW'(6);
  localparam logic [PMW-1:0] PM_INIT = PMW'(2 ** (PMW - 2));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_r;
  logic [PMW-1:0]   pm_r       [NS];
  logic [PMW-1:0]   pm_nxt_s   [NS];
  logic [DEPTH-1:0] surv_r     [NS];
  logic [DEPTH-1:0] surv_nxt_s [NS];
  logic [CW-1:0]    fill_r;
  logic [CW-1:0]    fcnt_s;
  logic [CW-1:0]    flush_rem_r;
  logic [IW-1:0]    flush_idx_r;
  logic             out_valid_r;
  logic             out_data_r;
  logic             out_last_r;
  logic             in_acc_s;
  logic             out_hs_s;

  // Encoder outputs {g1, g0} for input bit b leaving state s.
  function automatic logic [1:0] enc_bits(input logic [5:0] s, input logic b);
    logic [1:0] g;
    g[0] = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
    g[1] = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    return g;
  endfunction

  // Hamming distance over the positions that were not punctured.
  function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] er,
                                               input logic [1:0] expv);
    logic [1:0] d;
    d = (rx ^ expv) & ~er;
    return {1'b0, d[0]} + {1'b0, d[1]};
  endfunction

  assign s_axis_tready = ~areset & (state_r != FLUSH) & (~out_valid_r | m_axis_tready);
  assign in_acc_s      = s_axis_tvalid & s_axis_tready;
  assign out_hs_s      = out_valid_r & m_axis_tready;
  assign m_axis_tvalid = out_valid_r;
  assign m_axis_tdata  = out_data_r;
  assign m_axis_tlast  = out_last_r;

  // Survivor length after the current pair, saturating at DEPTH.
  assign fcnt_s = (fill_r == DEPTH_C) ? DEPTH_C : fill_r + CW'(1);

  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic [5:0] NXT = 6'(g);
    localparam logic [5:0] P0  = {1'b0, NXT[5:1]};
    localparam logic [5:0] P1  = {1'b1, NXT[5:1]};
    logic [1:0]     bm0_s, bm1_s;
    logic [PMW-1:0] c0_s, c1_s, diff_s;
    logic           sel_s;

    assign bm0_s  = branch_metric(s_axis_tdata, s_axis_tuser, enc_bits(P0, NXT[0]));
    assign bm1_s  = branch_metric(s_axis_tdata, s_axis_tuser, enc_bits(P1, NXT[0]));
    assign c0_s   = pm_r[P0] + {{(PMW-2){1'b0}}, bm0_s};
    assign c1_s   = pm_r[P1] + {{(PMW-2){1'b0}}, bm1_s};
    // Modulo compare: a negative difference means the s[5]=1 path is strictly better.
    assign diff_s = c1_s - c0_s;
    assign sel_s  = diff_s[PMW-1];
    assign pm_nxt_s[g]   = sel_s ? c1_s : c0_s;
    assign surv_nxt_s[g] = sel_s ? {surv_r[P1][DEPTH-2:0], NXT[0]}
                                 : {surv_r[P0][DEPTH-2:0], NXT[0]};
  end

  // Control FSM, path metrics, survivors and the registered output beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r     <= IDLE;
      fill_r      <= '0;
      flush_rem_r <= '0;
      flush_idx_r <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 1'b0;
      out_last_r  <= 1'b0;
      for (int i = 0; i < NS; i++) begin
        pm_r[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_r[i] <= '0;
      end
    end else begin
      if (out_hs_s) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE, RUN: begin
          if (in_acc_s) begin
            state_r <= RUN;
            pm_r    <= pm_nxt_s;
            surv_r  <= surv_nxt_s;
            fill_r  <= fcnt_s;
            if (fill_r == DEPTH_C) begin
              out_valid_r <= 1'b1;
              out_data_r  <= surv_r[0][DEPTH-1];
              out_last_r  <= 1'b0;
            end
            if (s_axis_tlast) begin
              if (fcnt_s > TAIL_C) begin
                state_r     <= FLUSH;
                flush_rem_r <= fcnt_s - TAIL_C;
                flush_idx_r <= IW'(fcnt_s - CW'(1));
              end else begin
                // Nothing but tail in the survivor: drop it and start afresh.
                state_r <= IDLE;
                fill_r  <= '0;
                for (int i = 0; i < NS; i++) begin
                  pm_r[i]   <= (i == 0) ? '0 : PM_INIT;
                  surv_r[i] <= '0;
                end
              end
            end
          end
        end
        FLUSH: begin
          if ((flush_rem_r != '0) && (~out_valid_r | m_axis_tready)) begin
            out_valid_r <= 1'b1;
            out_data_r  <= surv_r[0][flush_idx_r];
            out_last_r  <= (flush_rem_r == CW'(1));
            flush_rem_r <= flush_rem_r - CW'(1);
            flush_idx_r <= flush_idx_r - IW'(1);
          end else if (out_hs_s && out_last_r) begin
            state_r    <= IDLE;
            fill_r     <= '0;
            out_last_r <= 1'b0;
            for (int i = 0; i < NS; i++) begin
              pm_r[i]   <= (i == 0) ? '0 : PM_INIT;
              surv_r[i] <= '0;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder: a table of packets with expected counts,
// tlast position and first-output latency, plus a mid-packet reset sequence.
module tb_viterbi_decoder;

  localparam int DEPTH = 42;

  logic       aclk = 1'b0;
  logic       areset;
  logic [1:0] s_tdata, s_tuser;
  logic       s_tvalid, s_tready, s_tlast;
  logic       m_tdata, m_tvalid, m_tlast;
  logic       m_tready = 1'b1;

  always #5 aclk = ~aclk;

  viterbi_decoder #(.DEPTH(DEPTH), .PMW(8)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast)
  );

  typedef struct {
    string name;
    int    len;       // pairs including 6 tail pairs
    int    kind;      // 0 all-zero, 1 reference bits, 2 fresh random bits
    bit    err;       // single bit flips at pairs 20/60/140
    bit    erase;     // rate-3/4 puncturing with corrupted erased bits
    bit    bp;        // random output backpressure
    int    exp_cnt;   // expected decoded bits
    int    exp_first; // accepted pairs when m_tvalid first rises (-1: never)
  } vec_t;

  vec_t vecs[10];
  bit   ref_bits[200];
  bit   src[$];
  logic [1:0] pair_d[$], pair_u[$];
  bit   got_d[$], got_l[$];
  bit   bp_mode = 1'b0, mon_en = 1'b0, prev_stall = 1'b0;
  logic prev_d, prev_l;
  int   n_acc = 0, first_acc = -1;
  int   total = 0, bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Output side: choose tready for the coming edge, record handshakes, check stall hold.
  initial forever begin
    @(negedge aclk);
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_d);
        check("hold_last", m_tlast, prev_l);
      end
      if (m_tvalid && first_acc < 0) first_acc = n_acc;
      m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_tvalid && m_tready) begin
        got_d.push_back(m_tdata);
        got_l.push_back(m_tlast);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
    end else begin
      m_tready   = 1'b1;
      prev_stall = 1'b0;
    end
  end

  task automatic build(input vec_t v);
    logic [5:0] s;
    logic [1:0] d, u;
    bit b;
    s = 6'd0;
    src.delete(); pair_d.delete(); pair_u.delete();
    for (int i = 0; i < v.len; i++) begin
      if (v.kind == 0 || i >= v.len - 6) b = 1'b0;
      else if (v.kind == 1) b = ref_bits[i];
      else b = 1'($urandom_range(0, 1));
      src.push_back(b);
      d[0] = b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      d[1] = b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      u = 2'b00;
      if (v.err && (i == 20 || i == 140)) d[0] = ~d[0];
      if (v.err && i == 60) d[1] = ~d[1];
      if (v.erase && (i % 3) == 1) begin u = 2'b10; d[1] = ~d[1]; end
      if (v.erase && (i % 3) == 2) begin u = 2'b01; d[0] = ~d[0]; end
      pair_d.push_back(d);
      pair_u.push_back(u);
      s = {s[4:0], b};
    end
  endtask

  // Drive pairs 0..stop_at-1; tlast goes with pair len-1.
  task automatic send(input int len, input int stop_at);
    int i = 0;
    int guard = 0;
    while (i < stop_at && guard < 5000) begin
      @(negedge aclk); #1;
      s_tvalid = 1'b1;
      s_tdata  = pair_d[i];
      s_tuser  = pair_u[i];
      s_tlast  = (i == len - 1);
      if (s_tready) begin
        i++;
        n_acc++;
      end
      guard++;
    end
    check("send_done", i, stop_at);
    @(negedge aclk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int guard = 0;
    int errs = 0;
    int nlast = 0;
    int lpos = -1;
    build(v);
    got_d.delete(); got_l.delete();
    n_acc = 0; first_acc = -1; bp_mode = v.bp; mon_en = 1'b1;
    send(v.len, v.len);
    while (got_d.size() < v.exp_cnt && guard < 3000) begin
      @(negedge aclk);
      guard++;
    end
    repeat (30) @(negedge aclk);
    for (int i = 0; i < got_d.size(); i++) begin
      if (i < v.exp_cnt && got_d[i] != src[i]) errs++;
      if (got_l[i]) begin
        nlast++;
        if (lpos < 0) lpos = i;
      end
    end
    check({v.name, "_count"}, got_d.size(), v.exp_cnt);
    check({v.name, "_biterrs"}, errs, 0);
    check({v.name, "_nlast"}, nlast, (v.exp_cnt > 0) ? 1 : 0);
    check({v.name, "_lastpos"}, lpos, (v.exp_cnt > 0) ? v.exp_cnt - 1 : -1);
    check({v.name, "_first"}, first_acc, v.exp_first);
    check({v.name, "_idle_ready"}, s_tready, 1);
    bp_mode = 1'b0;
    mon_en  = 1'b0;
    @(negedge aclk);
  endtask

  initial begin
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = 2'b00; s_tuser = 2'b00; s_tlast = 1'b0;
    for (int i = 0; i < 200; i++) ref_bits[i] = 1'($urandom_range(0, 1));
    vecs[0] = '{"zero100",  100, 0, 1'b0, 1'b0, 1'b0,  94, 43};
    vecs[1] = '{"ref",      206, 1, 1'b0, 1'b0, 1'b0, 200, 43};
    vecs[2] = '{"ref_err",  206, 1, 1'b1, 1'b0, 1'b0, 200, 43};
    vecs[3] = '{"ref_eras", 206, 1, 1'b0, 1'b1, 1'b0, 200, 43};
    vecs[4] = '{"ref_bp",   206, 1, 1'b0, 1'b0, 1'b1, 200, 43};
    vecs[5] = '{"short10",   10, 2, 1'b0, 1'b0, 1'b0,   4, 10};
    vecs[6] = '{"tiny5",      5, 2, 1'b0, 1'b0, 1'b0,   0, -1};
    vecs[7] = '{"len42",     42, 2, 1'b0, 1'b0, 1'b0,  36, 42};
    vecs[8] = '{"len43",     43, 2, 1'b0, 1'b0, 1'b0,  37, 43};
    vecs[9] = '{"zero50",    50, 0, 1'b0, 1'b0, 1'b0,  44, 43};

    repeat (3) @(negedge aclk);
    check("rst_tready", s_tready, 0);
    check("rst_mvalid", m_tvalid, 0);
    check("rst_mdata", m_tdata, 0);
    check("rst_mlast", m_tlast, 0);
    areset = 1'b0;
    #1;
    check("idle_tready", s_tready, 1);

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Abandon the reference packet at pair 80, then decode a clean packet.
    build(vecs[1]);
    n_acc = 0; first_acc = -1; mon_en = 1'b1;
    send(206, 80);
    mon_en = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check("midrst_tready", s_tready, 0);
    check("midrst_mvalid", m_tvalid, 0);
    check("midrst_mdata", m_tdata, 0);
    check("midrst_mlast", m_tlast, 0);
    areset = 1'b0;
    run_vec(vecs[9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
